nor_gate_checker: RTL and testbench

Self-checking stimulus/response engine that sits on the other end of a two-input, six-output NOR-built gate block. It drives the block's A/B inputs through all four combinations and waits a programmable settle time. It then samples the six gate outputs against golden values and reports a sticky per-gate fail mask, first failing vector and failing-vector count. Used as the on-chip/bench tester for the NOR/NAND gate-library blocks.

---
 rtl/nor_gate_checker.sv | 102 ++++++++++
 tb/tb_nor_gate_checker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/nor_gate_checker.sv
// Stimulus/response checker for a two-input, six-output gate block: walks {A,B}
// through 00..11, waits SETTLE_CYCLES per vector, and collects sticky mismatch results.
module nor_gate_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       drive_a,
  output logic       drive_b,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  input  logic       nand_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic [1:0] first_fail_vec,
  output logic [2:0] fail_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [5:0] golden, actual, mism;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'd3) ? IDLE : SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx stays 0 in IDLE, so the drive pins return to {0,0} between runs.
  always_comb begin
    drive_a = idx[1];
    drive_b = idx[0];
    busy    = (state != IDLE);
    pass    = done & (fail_mask == 6'd0);
  end

  always_comb begin
    golden = {~(drive_a ^ drive_b), drive_a ^ drive_b, ~(drive_a & drive_b),
              ~drive_a, drive_a | drive_b, drive_a & drive_b};
    actual = {xnor_in, xor_in, nand_in, not_in, or_in, and_in};
    mism   = golden ^ actual;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= 2'd0;
      cnt            <= 4'd0;
      done           <= 1'b0;
      fail_mask      <= 6'd0;
      first_fail_vec <= 2'd0;
      fail_count     <= 3'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx            <= 2'd0;
          cnt            <= CNT_LOAD;
          done           <= 1'b0;
          fail_mask      <= 6'd0;
          first_fail_vec <= 2'd0;
          fail_count     <= 3'd0;
        end
        SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        SAMPLE: begin
          fail_mask <= fail_mask | mism;
          if (mism != 6'd0) begin
            fail_count <= fail_count + 3'd1;
            if (fail_count == 3'd0) first_fail_vec <= idx;
          end
          if (idx == 2'd3) begin
            idx  <= 2'd0;
            done <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
            cnt <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_gate_checker.sv
// Directed bench for nor_gate_checker: behavioural gate model with injectable faults,
// plus a second instance at SETTLE_CYCLES=1 for the short-settle timing.
module tb_nor_gate_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       drive_a, drive_b, drive_a1, drive_b1;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [5:0] fail_mask, fail_mask1;
  logic [1:0] first_fail_vec, first_fail_vec1;
  logic [2:0] fail_count, fail_count1;
  int         fault;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // fault 0: correct gates, 1: xor stuck at 0, 2: and/nand swapped
  wire g_and  = (fault == 2) ? ~(drive_a & drive_b) : (drive_a & drive_b);
  wire g_nand = (fault == 2) ? (drive_a & drive_b) : ~(drive_a & drive_b);
  wire g_xor  = (fault == 1) ? 1'b0 : (drive_a ^ drive_b);

  nor_gate_checker #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .drive_a(drive_a), .drive_b(drive_b),
    .and_in(g_and), .or_in(drive_a | drive_b), .not_in(~drive_a),
    .nand_in(g_nand), .xor_in(g_xor), .xnor_in(~(drive_a ^ drive_b)),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .first_fail_vec(first_fail_vec), .fail_count(fail_count)
  );

  nor_gate_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .drive_a(drive_a1), .drive_b(drive_b1),
    .and_in(drive_a1 & drive_b1), .or_in(drive_a1 | drive_b1), .not_in(~drive_a1),
    .nand_in(~(drive_a1 & drive_b1)), .xor_in(drive_a1 ^ drive_b1),
    .xnor_in(~(drive_a1 ^ drive_b1)),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail_mask1),
    .first_fail_vec(first_fail_vec1), .fail_count(fail_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge right after the start edge.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
  endtask

  // Full run from the start edge: each vector held 3 cycles, done after 12 edges.
  task automatic run_check(input string tag, input logic [5:0] mask,
                           input logic [1:0] ffv, input logic [2:0] cnt);
    for (int i = 0; i < 12; i++) begin
      chk({tag, " drive"}, {30'd0, drive_a, drive_b}, 32'(i / 3));
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " done low"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
    chk({tag, " drive end"}, {30'd0, drive_a, drive_b}, 32'd0);
    chk({tag, " mask"}, {26'd0, fail_mask}, {26'd0, mask});
    chk({tag, " ffv"}, {30'd0, first_fail_vec}, {30'd0, ffv});
    chk({tag, " count"}, {29'd0, fail_count}, {29'd0, cnt});
    chk({tag, " pass"}, {31'd0, pass}, {31'd0, (mask == 6'd0)});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; fault = 0;
    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst pass", {31'd0, pass}, 32'd0);
    chk("rst drive", {30'd0, drive_a, drive_b}, 32'd0);
    chk("rst mask", {26'd0, fail_mask}, 32'd0);
    chk("rst count", {29'd0, fail_count}, 32'd0);
    @(negedge clk) rst = 1'b0;

    fault = 0; do_start(); run_check("good", 6'b000000, 2'b00, 3'd0);
    fault = 1; do_start(); run_check("xor0", 6'b010000, 2'b01, 3'd2);
    fault = 2; do_start(); run_check("swap", 6'b001001, 2'b00, 3'd4);

    // start pulsed mid-run is ignored; restart after done clears results
    fault = 1; do_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(negedge clk);
    chk("ign done early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("ign done", {31'd0, done}, 32'd1);
    chk("ign mask", {26'd0, fail_mask}, 32'b010000);
    chk("ign count", {29'd0, fail_count}, 32'd2);
    @(negedge clk);
    fault = 0; do_start();
    chk("restart done low", {31'd0, done}, 32'd0);
    chk("restart mask clr", {26'd0, fail_mask}, 32'd0);
    chk("restart count clr", {29'd0, fail_count}, 32'd0);
    chk("restart ffv clr", {30'd0, first_fail_vec}, 32'd0);
    repeat (11) @(negedge clk);
    chk("restart done early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("restart done", {31'd0, done}, 32'd1);
    chk("restart pass", {31'd0, pass}, 32'd1);

    // async reset mid-cycle after vector 1 has already recorded a mismatch
    fault = 1; do_start();
    repeat (7) @(negedge clk);
    chk("pre-rst mask", {26'd0, fail_mask}, 32'b010000);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst drive", {30'd0, drive_a, drive_b}, 32'd0);
    chk("arst mask", {26'd0, fail_mask}, 32'd0);
    chk("arst count", {29'd0, fail_count}, 32'd0);
    chk("arst ffv", {30'd0, first_fail_vec}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    @(negedge clk) rst = 1'b0;
    fault = 0; do_start(); run_check("post-rst", 6'b000000, 2'b00, 3'd0);

    // SETTLE_CYCLES=1: each vector held 2 cycles, done after 8 edges
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    @(negedge clk) start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s1 drive", {30'd0, drive_a1, drive_b1}, 32'(i / 2));
      chk("s1 busy", {31'd0, busy1}, 32'd1);
      chk("s1 done low", {31'd0, done1}, 32'd0);
      @(negedge clk);
    end
    chk("s1 done", {31'd0, done1}, 32'd1);
    chk("s1 pass", {31'd0, pass1}, 32'd1);
    chk("s1 count", {29'd0, fail_count1}, 32'd0);
    chk("s1 mask", {26'd0, fail_mask1}, 32'd0);
    chk("s1 ffv", {30'd0, first_fail_vec1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
